// File: rtl/uart_rx_ext.sv
// UART receiver: 16x oversampled deframer (5-9 data bits, optional parity,
// 1/2 stop bits) feeding a show-ahead receive FIFO with sticky error flags.
module uart_rx_ext #(
  parameter int DBIT       = 8,
  parameter int DVSR       = 326,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_AW    = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               rx,
  input  logic               rd_uart,
  input  logic               clr_err,
  output logic [DBIT-1:0]    oData,
  output logic               rx_empty,
  output logic               rx_full,
  output logic [FIFO_AW:0]   oCount,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun_err
);

  localparam int TW    = $clog2(DVSR);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [TW-1:0]    TMAX  = TW'(DVSR - 1);
  localparam logic [4:0]       SLAST = 5'(SB_TICK - 1);
  localparam logic [3:0]       NMAX  = 4'(DBIT - 1);
  localparam logic [FIFO_AW:0] FULLC = (FIFO_AW + 1)'(DEPTH);
  localparam logic             PODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                sync1_q, sync1_d, rxs_q, rxs_d;
  logic [4:0]          s_q, s_d;
  logic [3:0]          n_q, n_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                perr_q, perr_d;
  logic [FIFO_AW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [FIFO_AW:0]    cnt_q, cnt_d;
  logic                fe_q, fe_d, pe_q, pe_d, oe_q, oe_d;
  logic [DBIT-1:0]     mem_q [DEPTH];
  logic                tick, done, empty, full, pop, push, ovr;

  always_comb begin
    tick    = (tcnt_q == TMAX);
    tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
    sync1_d = rx;
    rxs_d   = sync1_q;
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    perr_d  = perr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (tick) begin
        // Mid start bit: a line already back high was only a glitch.
        if (s_q == 5'd7) begin
          if (!rxs_q) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
            perr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (s_q == 5'd15) begin
          s_d = '0;
          b_d = {rxs_q, b_q[DBIT-1:1]};
          if (n_q == NMAX) state_d = (PARITY_EN != 0) ? PAR : STOP;
          else             n_d = n_q + 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      PAR: if (tick) begin
        if (s_q == 5'd15) begin
          perr_d  = ((^b_q) ^ rxs_q) != PODD;
          s_d     = '0;
          state_d = STOP;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (s_q == SLAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rx_empty=0 means oData is valid; rd_uart pops the head only while valid.
  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == FULLC);
    pop    = rd_uart && !empty;
    push   = done && (!full || pop);
    ovr    = done && full && !pop;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    fe_d = (fe_q & ~clr_err) | (done & ~rxs_q);
    pe_d = (pe_q & ~clr_err) | (done & perr_q);
    oe_d = (oe_q & ~clr_err) | ovr;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      perr_q  <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      perr_q  <= perr_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      oe_q    <= oe_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push) mem_q[wptr_q] <= b_q;
  end

  assign oData       = empty ? '0 : mem_q[rptr_q];
  assign rx_empty    = empty;
  assign rx_full     = full;
  assign oCount      = cnt_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun_err = oe_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: four instances (8N1, 8E1, shallow FIFO, 7-bit/2-stop)
// driven by directed serial frames and checked against an expected-word queue.
module tb_uart_rx_ext;

  logic       clk;
  logic [3:0] rst_v, rx_v, rd_v, clr_v;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       e0, e1, e2, e3, f0, f1, f2, f3;
  logic [4:0] c0, c1, c3;
  logic [2:0] c2;
  logic       fe0, fe1, fe2, fe3, pe0, pe1, pe2, pe3, oe0, oe1, oe2, oe3;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ext #(.DVSR(4)) u0 (
    .iClk(clk), .iRst(rst_v[0]), .rx(rx_v[0]), .rd_uart(rd_v[0]), .clr_err(clr_v[0]),
    .oData(d0), .rx_empty(e0), .rx_full(f0), .oCount(c0),
    .frame_err(fe0), .parity_err(pe0), .overrun_err(oe0));

  uart_rx_ext #(.DVSR(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .iClk(clk), .iRst(rst_v[1]), .rx(rx_v[1]), .rd_uart(rd_v[1]), .clr_err(clr_v[1]),
    .oData(d1), .rx_empty(e1), .rx_full(f1), .oCount(c1),
    .frame_err(fe1), .parity_err(pe1), .overrun_err(oe1));

  uart_rx_ext #(.DVSR(4), .FIFO_AW(2)) u2 (
    .iClk(clk), .iRst(rst_v[2]), .rx(rx_v[2]), .rd_uart(rd_v[2]), .clr_err(clr_v[2]),
    .oData(d2), .rx_empty(e2), .rx_full(f2), .oCount(c2),
    .frame_err(fe2), .parity_err(pe2), .overrun_err(oe2));

  uart_rx_ext #(.DBIT(7), .DVSR(4), .SB_TICK(32)) u3 (
    .iClk(clk), .iRst(rst_v[3]), .rx(rx_v[3]), .rd_uart(rd_v[3]), .clr_err(clr_v[3]),
    .oData(d3), .rx_empty(e3), .rx_full(f3), .oCount(c3),
    .frame_err(fe3), .parity_err(pe3), .overrun_err(oe3));

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_out(input int w, output logic [31:0] data, output logic [31:0] empty,
                         output logic [31:0] full, output logic [31:0] cnt,
                         output logic [31:0] fe, output logic [31:0] pe, output logic [31:0] oe);
    case (w)
      0: begin data = 32'(d0); empty = 32'(e0); full = 32'(f0); cnt = 32'(c0);
               fe = 32'(fe0); pe = 32'(pe0); oe = 32'(oe0); end
      1: begin data = 32'(d1); empty = 32'(e1); full = 32'(f1); cnt = 32'(c1);
               fe = 32'(fe1); pe = 32'(pe1); oe = 32'(oe1); end
      2: begin data = 32'(d2); empty = 32'(e2); full = 32'(f2); cnt = 32'(c2);
               fe = 32'(fe2); pe = 32'(pe2); oe = 32'(oe2); end
      default: begin data = 32'(d3); empty = 32'(e3); full = 32'(f3); cnt = 32'(c3);
               fe = 32'(fe3); pe = 32'(pe3); oe = 32'(oe3); end
    endcase
  endtask

  task automatic expect_head(input int w, input string tag);
    logic [31:0] data, empty, full, cnt, fe, pe, oe;
    get_out(w, data, empty, full, cnt, fe, pe, oe);
    chk({tag, "_count"}, cnt, 32'(exp_q.size()));
    if (exp_q.size() == 0) begin
      chk({tag, "_data"}, data, 32'h0);
      chk({tag, "_empty"}, empty, 32'd1);
    end else begin
      chk({tag, "_data"}, data, exp_q[0]);
      chk({tag, "_empty"}, empty, 32'd0);
    end
  endtask

  task automatic chk_flags(input int w, input string tag, input logic fe_x,
                           input logic pe_x, input logic oe_x);
    logic [31:0] data, empty, full, cnt, fe, pe, oe;
    get_out(w, data, empty, full, cnt, fe, pe, oe);
    chk({tag, "_frame_err"}, fe, 32'(fe_x));
    chk({tag, "_parity_err"}, pe, 32'(pe_x));
    chk({tag, "_overrun_err"}, oe, 32'(oe_x));
  endtask

  task automatic chk_full(input int w, input string tag, input logic full_x);
    logic [31:0] data, empty, full, cnt, fe, pe, oe;
    get_out(w, data, empty, full, cnt, fe, pe, oe);
    chk({tag, "_full"}, full, 32'(full_x));
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input int w, input logic [31:0] data, input int nbits,
                            input int par_en, input logic par_bit, input logic stop_val,
                            input int stop_clks);
    @(negedge clk) rx_v[w] = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_v[w] = data[i];
      repeat (64) @(negedge clk);
    end
    if (par_en != 0) begin
      rx_v[w] = par_bit;
      repeat (64) @(negedge clk);
    end
    rx_v[w] = stop_val;
    repeat (stop_clks) @(negedge clk);
    rx_v[w] = 1'b1;
  endtask

  task automatic pop(input int w, input string tag);
    @(negedge clk) rd_v[w] = 1'b1;
    @(negedge clk) rd_v[w] = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    expect_head(w, tag);
  endtask

  task automatic pulse_clr(input int w);
    @(negedge clk) clr_v[w] = 1'b1;
    @(negedge clk) clr_v[w] = 1'b0;
  endtask

  function automatic logic [31:0] fsm_state(input int w);
    return (w == 0) ? 32'(u0.state_q) : 32'(u3.state_q);
  endfunction

  // Reset pulse in the middle of DATA bit 3 of 0xF0, then a clean 0x3C.
  task automatic reset_mid(input int w, input int nbits, input int stop_clks, input string tag);
    logic [7:0] f0v;
    f0v = 8'hF0;
    @(negedge clk) rx_v[w] = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_v[w] = f0v[i];
      repeat (64) @(negedge clk);
    end
    rx_v[w] = f0v[3];
    repeat (32) @(negedge clk);
    chk({tag, "_pre_state"}, fsm_state(w), 32'd2);
    rst_v[w] = 1'b1;
    @(negedge clk);
    rst_v[w] = 1'b0;
    rx_v[w]  = 1'b1;
    exp_q.delete();
    chk({tag, "_state"}, fsm_state(w), 32'd0);
    expect_head(w, tag);
    chk_full(w, tag, 1'b0);
    chk_flags(w, tag, 1'b0, 1'b0, 1'b0);
    repeat (128) @(negedge clk);
    exp_q.push_back(32'h3C);
    send_frame(w, 32'h3C, nbits, 0, 1'b0, 1'b1, stop_clks);
    expect_head(w, {tag, "_after"});
    chk_flags(w, {tag, "_after"}, 1'b0, 1'b0, 1'b0);
    pop(w, {tag, "_after_pop"});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    rst_v = 4'hF; rx_v = 4'hF; rd_v = 4'h0; clr_v = 4'h0;
    repeat (3) @(negedge clk);
    rst_v = 4'h0;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      expect_head(w, "reset");
      chk_full(w, "reset", 1'b0);
      chk_flags(w, "reset", 1'b0, 1'b0, 1'b0);
    end

    // Basic 8N1
    exp_q.push_back(32'hA5);
    send_frame(0, 32'hA5, 8, 0, 1'b0, 1'b1, 64);
    expect_head(0, "basic");
    chk_flags(0, "basic", 1'b0, 1'b0, 1'b0);
    pop(0, "basic_pop");

    // Glitch rejection: 4 ticks low
    @(negedge clk) rx_v[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (192) @(negedge clk);
    expect_head(0, "glitch");
    chk_flags(0, "glitch", 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h3C);
    send_frame(0, 32'h3C, 8, 0, 1'b0, 1'b1, 64);
    expect_head(0, "glitch_next");
    pop(0, "glitch_next_pop");

    // Framing error: stop bit low past its centre, then line high
    exp_q.push_back(32'h55);
    send_frame(0, 32'h55, 8, 0, 1'b0, 1'b0, 44);
    repeat (100) @(negedge clk);
    expect_head(0, "ferr");
    chk_flags(0, "ferr", 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h12);
    send_frame(0, 32'h12, 8, 0, 1'b0, 1'b1, 64);
    expect_head(0, "ferr_next");
    pop(0, "ferr_next_pop");

    // Reset mid-frame with a word and frame_err still pending
    reset_mid(0, 8, 64, "rst_mid8");

    // Parity (even)
    exp_q.push_back(32'h03);
    send_frame(1, 32'h03, 8, 1, 1'b0, 1'b1, 64);
    expect_head(1, "par_ok");
    chk_flags(1, "par_ok", 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h03);
    send_frame(1, 32'h03, 8, 1, 1'b1, 1'b1, 64);
    expect_head(1, "par_bad");
    chk_flags(1, "par_bad", 1'b0, 1'b1, 1'b0);
    pulse_clr(1);
    chk_flags(1, "par_clr", 1'b0, 1'b0, 1'b0);
    pop(1, "par_pop1");
    pop(1, "par_pop2");

    // Overrun on a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(32'(i));
      send_frame(2, 32'(i), 8, 0, 1'b0, 1'b1, 64);
    end
    expect_head(2, "ovr");
    chk_full(2, "ovr", 1'b1);
    chk_flags(2, "ovr", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pop(2, "ovr_pop");
    pulse_clr(2);
    chk_flags(2, "ovr_clr", 1'b0, 1'b0, 1'b0);

    // Interleaved writes and pops across pointer wrap
    for (int i = 0; i < 2; i++) begin
      v = 32'($urandom_range(0, 255));
      exp_q.push_back(v);
      send_frame(2, v, 8, 0, 1'b0, 1'b1, 64);
    end
    for (int i = 0; i < 8; i++) begin
      v = 32'($urandom_range(0, 255));
      exp_q.push_back(v);
      send_frame(2, v, 8, 0, 1'b0, 1'b1, 64);
      pop(2, "wrap_pop");
    end
    pop(2, "wrap_drain");
    pop(2, "wrap_drain");

    // Pop coincident with a completion while full: no overrun
    for (int i = 0; i < 4; i++) begin
      v = 32'($urandom_range(0, 255));
      exp_q.push_back(v);
      send_frame(2, v, 8, 0, 1'b0, 1'b1, 64);
    end
    chk_full(2, "hold_pre", 1'b1);
    exp_q.push_back(32'h5A);
    fork
      send_frame(2, 32'h5A, 8, 0, 1'b0, 1'b1, 64);
      begin
        logic got;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
          @(negedge clk);
          if (u2.done) begin
            rd_v[2] = 1'b1;
            got = 1'b1;
            chk("hold_head", 32'(d2), exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        @(negedge clk) rd_v[2] = 1'b0;
        chk("hold_done_seen", 32'(got), 32'd1);
      end
    join
    expect_head(2, "hold");
    chk_full(2, "hold", 1'b1);
    chk_flags(2, "hold", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop(2, "hold_drain");

    // 7 data bits, 2 stop bits, with reset mid-frame
    exp_q.push_back(32'h15);
    send_frame(3, 32'h15, 7, 0, 1'b0, 1'b1, 128);
    expect_head(3, "d7");
    reset_mid(3, 7, 128, "rst_mid7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
